// File: rtl/lsu.sv
// Load/store unit: one outstanding valid/ready data-bus access, with alignment
// checking, store lane replication, load extraction and a bus timeout.
module lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  input  logic        lsu_wen,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_unsigned,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        lsu_busy,
  output logic        mem_reqValid,
  input  logic        mem_reqReady,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  state_dbg
);

  // Bus handshake: a request transfers on a rising edge where mem_reqValid and
  // mem_reqReady are both high; mem_reqValid stays high and the request fields
  // stay stable until that edge (or until the timeout abandons it). A response
  // transfers on any edge with mem_respValid high while the unit is in WAIT.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          wen_q;
  logic          uns_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;

  logic          misaligned;
  logic          timeout;
  logic [31:0]   shifted;
  logic [31:0]   extracted;
  logic [31:0]   lane_wdata;
  logic [3:0]    lane_wstrb;
  logic          in_req;
  logic          bus_write;

  always_comb begin
    misaligned = 1'b0;
    case (lsu_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = lsu_addr[0];
      2'd2:    misaligned = (lsu_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Greater-or-equal also covers a request accepted on the last counted cycle,
  // which enters WAIT one count past the limit.
  assign timeout = (cnt >= CW'(TIMEOUT_CYCLES - 1));

  assign shifted = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    extracted = mem_rdata;
    case (size_q)
      2'd0:    extracted = uns_q ? {24'd0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    extracted = uns_q ? {16'd0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      default: extracted = mem_rdata;
    endcase
  end

  always_comb begin
    lane_wdata = wdata_q;
    lane_wstrb = 4'b1111;
    case (size_q)
      2'd0: begin
        lane_wdata = {4{wdata_q[7:0]}};
        lane_wstrb = 4'b0001 << addr_q[1:0];
      end
      2'd1: begin
        lane_wdata = {2{wdata_q[15:0]}};
        lane_wstrb = 4'b0011 << addr_q[1:0];
      end
      default: begin
        lane_wdata = wdata_q;
        lane_wstrb = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (reqValid) begin
            wen_q   <= lsu_wen;
            uns_q   <= lsu_unsigned;
            size_q  <= lsu_size;
            addr_q  <= lsu_addr;
            wdata_q <= lsu_wdata;
            cnt     <= '0;
            state   <= misaligned ? ERR : REQ;
          end
        end
        REQ: begin
          cnt <= cnt + CW'(1);
          if (mem_reqReady) begin
            state <= WAIT;
          end else if (timeout) begin
            state <= ERR;
          end
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          if (mem_respValid) begin
            rdata_q <= wen_q ? 32'd0 : extracted;
            state   <= DONE;
          end else if (timeout) begin
            state <= ERR;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_req    = (state == REQ);
  assign bus_write = in_req & wen_q;

  assign mem_reqValid  = in_req;
  assign mem_wen       = bus_write;
  assign mem_addr      = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wdata     = bus_write ? lane_wdata : 32'd0;
  assign mem_wstrb     = bus_write ? lane_wstrb : 4'b0000;

  assign lsu_respValid = (state == DONE) || (state == ERR);
  assign lsu_err       = (state == ERR);
  assign lsu_rdata     = (state == DONE) ? rdata_q : 32'd0;
  assign lsu_busy      = (state != IDLE);
  assign state_dbg     = state;

endmodule
